s1_entrada_jogada: RTL and testbench

Player-side front end that produces the event and timing inputs consumed by the game control unit. The control unit sends zeraT/contaT/zeraT2/contaT2 and receives jogada, timeout and muda_leds.
Raw buttons are synchronized, debounced and accepted only when exactly one is pressed. The block then emits a one-cycle jogada pulse and latches the pressed code.

---
 rtl/s1_pkg.sv | 21 ++
 rtl/s1_temporizador.sv | 62 ++++++
 rtl/s1_entrada_jogada.sv | 143 ++++++++++++++
 tb/tb_s1_entrada_jogada.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/s1_pkg.sv
// Shared types for the player input front end: button FSM encoding,
// timer operating mode and a one-hot test used to reject multi-button presses.
package s1_pkg;

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        FILTRANDO    = 2'd1,
        ACEITO       = 2'd2,
        ESPERA_SOLTA = 2'd3
    } estado_botao_t;

    typedef enum logic {
        MODO_SATURA  = 1'b0,
        MODO_CICLICO = 1'b1
    } modo_t;

    function automatic logic is_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/s1_temporizador.sv
// Clearable up-counter modulo MODULO; saturates at MODULO-1 (level fim)
// or wraps to 0 (fim pulses on the wrapping cycle), selected by MODE.
module s1_temporizador
    import s1_pkg::*;
#(
    parameter int    MODULO = 8,
    parameter modo_t MODE   = MODO_SATURA
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        zera,
    input  logic                        conta,
    output logic [$clog2(MODULO)-1:0]   contagem,
    output logic                        fim
);

    localparam int           W      = $clog2(MODULO);
    localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;
    logic         no_ultimo_s;

    assign no_ultimo_s = (cont_q == ULTIMO);
    assign contagem    = cont_q;

    // Next count: clear wins over count; the last value either holds or wraps.
    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (conta) begin
            if (no_ultimo_s) begin
                cont_d = (MODE == MODO_CICLICO) ? '0 : cont_q;
            end else begin
                cont_d = cont_q + W'(1);
            end
        end else begin
            cont_d = cont_q;
        end
    end

    // End-of-count flag; in wrap mode it is qualified by the inputs of this cycle.
    always_comb begin
        fim = 1'b0;
        if (MODE == MODO_CICLICO) begin
            fim = conta & ~zera & no_ultimo_s;
        end else begin
            fim = no_ultimo_s;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

endmodule

// File: rtl/s1_entrada_jogada.sv
// Player front end: synchronizes and debounces the buttons, accepts single presses
// as a one-cycle jogada pulse, and hosts the play-timeout and LED-step timers.
module s1_entrada_jogada
    import s1_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 5000,
    parameter int PERIODO_LEDS    = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                zeraT,
    input  logic                contaT,
    input  logic                zeraT2,
    input  logic                contaT2,
    output logic                jogada,
    output logic [N_BOTOES-1:0] codigo_jogada,
    output logic                timeout,
    output logic                muda_leds,
    output logic [1:0]          db_estado_botao
);

    localparam int            WD         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [WD-1:0] DEB_ULTIMO = WD'(DEBOUNCE_CYCLES - 1);

    logic [N_BOTOES-1:0] sync1_q;
    logic [N_BOTOES-1:0] sinc_q;
    estado_botao_t       estado_q, estado_d;
    logic [N_BOTOES-1:0] cand_q, cand_d;
    logic [WD-1:0]       cont_deb_q, cont_deb_d;
    logic [N_BOTOES-1:0] codigo_q, codigo_d;

    logic [$clog2(TIMEOUT_CYCLES)-1:0] cont_t_unused_s;
    logic [$clog2(PERIODO_LEDS)-1:0]   cont_t2_unused_s;

    // Two-stage synchronizer for the asynchronous button pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sinc_q  <= '0;
        end else begin
            sync1_q <= botoes;
            sinc_q  <= sync1_q;
        end
    end

    // Button FSM next state: debounce press, pulse once, then debounce full release.
    always_comb begin
        estado_d   = estado_q;
        cand_d     = cand_q;
        cont_deb_d = cont_deb_q;
        codigo_d   = codigo_q;
        case (estado_q)
            OCIOSO: begin
                if (sinc_q != '0) begin
                    cand_d     = sinc_q;
                    cont_deb_d = '0;
                    estado_d   = FILTRANDO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            FILTRANDO: begin
                if (sinc_q != cand_q) begin
                    estado_d = OCIOSO;
                end else if (cont_deb_q == DEB_ULTIMO) begin
                    cont_deb_d = '0;
                    if (is_one_hot(32'(cand_q))) begin
                        codigo_d = cand_q;
                        estado_d = ACEITO;
                    end else begin
                        estado_d = ESPERA_SOLTA;
                    end
                end else begin
                    cont_deb_d = cont_deb_q + WD'(1);
                end
            end
            ACEITO: begin
                cont_deb_d = '0;
                estado_d   = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (sinc_q != '0) begin
                    cont_deb_d = '0;
                end else if (cont_deb_q == DEB_ULTIMO) begin
                    estado_d = OCIOSO;
                end else begin
                    cont_deb_d = cont_deb_q + WD'(1);
                end
            end
            default: begin
                estado_d   = OCIOSO;
                cont_deb_d = '0;
            end
        endcase
    end

    // Button FSM registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            cand_q     <= '0;
            cont_deb_q <= '0;
            codigo_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            cand_q     <= cand_d;
            cont_deb_q <= cont_deb_d;
            codigo_q   <= codigo_d;
        end
    end

    assign jogada          = (estado_q == ACEITO);
    assign codigo_jogada   = codigo_q;
    assign db_estado_botao = estado_q;

    s1_temporizador #(
        .MODULO (TIMEOUT_CYCLES),
        .MODE   (MODO_SATURA)
    ) u_timer_t (
        .clock    (clock),
        .reset_n  (reset_n),
        .zera     (zeraT),
        .conta    (contaT),
        .contagem (cont_t_unused_s),
        .fim      (timeout)
    );

    s1_temporizador #(
        .MODULO (PERIODO_LEDS),
        .MODE   (MODO_CICLICO)
    ) u_timer_t2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .zera     (zeraT2),
        .conta    (contaT2),
        .contagem (cont_t2_unused_s),
        .fim      (muda_leds)
    );

endmodule

// File: tb/tb_s1_entrada_jogada.sv
// Bench for s1_entrada_jogada: per-cycle vectors queued as expectations and
// compared one clock later; small parameters so timers wrap quickly.
module tb_s1_entrada_jogada;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] botoes;
    logic       zeraT, contaT, zeraT2, contaT2;
    logic       jogada;
    logic [3:0] codigo_jogada;
    logic       timeout, muda_leds;
    logic [1:0] db_estado_botao;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] MJ = 5'b10000;
    localparam logic [4:0] MC = 5'b01000;
    localparam logic [4:0] ME = 5'b00100;
    localparam logic [4:0] MT = 5'b00010;
    localparam logic [4:0] MM = 5'b00001;

    typedef struct {
        logic       rn;
        logic [3:0] b;
        logic       zt, ct, zt2, ct2;
        logic [4:0] m;
        logic       jog;
        logic [3:0] cod;
        logic [1:0] est;
        logic       to, ml;
    } vec_t;

    vec_t sb_q[$];
    vec_t tab[10];

    s1_entrada_jogada #(
        .N_BOTOES        (4),
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (20),
        .PERIODO_LEDS    (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .botoes          (botoes),
        .zeraT           (zeraT),
        .contaT          (contaT),
        .zeraT2          (zeraT2),
        .contaT2         (contaT2),
        .jogada          (jogada),
        .codigo_jogada   (codigo_jogada),
        .timeout         (timeout),
        .muda_leds       (muda_leds),
        .db_estado_botao (db_estado_botao)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic rn, input logic [3:0] b,
                                input logic zt, input logic ct, input logic zt2, input logic ct2,
                                input logic [4:0] m, input logic jog, input logic [3:0] cod,
                                input logic [1:0] est, input logic to, input logic ml);
        vec_t v;
        v.rn = rn; v.b = b; v.zt = zt; v.ct = ct; v.zt2 = zt2; v.ct2 = ct2;
        v.m = m; v.jog = jog; v.cod = cod; v.est = est; v.to = to; v.ml = ml;
        return v;
    endfunction

    // Expected state i cycles after a press is first driven (k = cycle 0).
    function automatic logic [1:0] est_press(input int i, input bit valido);
        if (i < 2)                return 2'd0;
        else if (i < 6)           return 2'd1;
        else if (i == 6 && valido) return 2'd2;
        else                      return 2'd3;
    endfunction

    task automatic cmp(input string nome, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", nome, got, exp, $time);
        end
    endtask

    task automatic aplica(input vec_t v);
        vec_t e;
        reset_n = v.rn; botoes = v.b;
        zeraT = v.zt; contaT = v.ct; zeraT2 = v.zt2; contaT2 = v.ct2;
        sb_q.push_back(v);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (e.m[4]) cmp("jogada",          {3'b000, jogada},          {3'b000, e.jog});
            if (e.m[3]) cmp("codigo_jogada",   codigo_jogada,             e.cod);
            if (e.m[2]) cmp("db_estado_botao", {2'b00, db_estado_botao},  {2'b00, e.est});
            if (e.m[1]) cmp("timeout",         {3'b000, timeout},         {3'b000, e.to});
            if (e.m[0]) cmp("muda_leds",       {3'b000, muda_leds},       {3'b000, e.ml});
        end
        @(negedge clock);
    endtask

    task automatic bt(input logic rn, input logic [3:0] b, input logic [4:0] m,
                      input logic jog, input logic [3:0] cod, input logic [1:0] est, input logic to);
        aplica(mk(rn, b, 1'b0, 1'b0, 1'b0, 1'b0, m, jog, cod, est, to, 1'b0));
    endtask

    task automatic tmr(input logic zt, input logic ct, input logic zt2, input logic ct2,
                       input logic [4:0] m, input logic to, input logic ml);
        aplica(mk(1'b1, 4'b0000, zt, ct, zt2, ct2, m, 1'b0, 4'b0000, 2'd0, to, ml));
    endtask

    task automatic solta(input logic [3:0] cod, input logic to);
        for (int i = 0; i < 5; i++) bt(1'b1, 4'b0000, MJ | ME | MT, 1'b0, cod, 2'd3, to);
        bt(1'b1, 4'b0000, MJ | MC | ME | MT, 1'b0, cod, 2'd0, to);
    endtask

    initial begin
        // Reset, then a clean single press of button 1.
        tab[0] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, MJ | MC | ME | MT | MM, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tab[1] = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, MJ | MC | ME | MT | MM, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tab[2] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | ME, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tab[3] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | ME, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        tab[4] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | ME, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        tab[5] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | ME, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        tab[6] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | ME, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        tab[7] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | MC | ME, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        tab[8] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | MC | ME, 1'b1, 4'b0010, 2'd2, 1'b0, 1'b0);
        tab[9] = mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, MJ | MC | ME, 1'b0, 4'b0010, 2'd3, 1'b0, 1'b0);

        reset_n = 1'b0; botoes = 4'b0000;
        zeraT = 1'b0; contaT = 1'b0; zeraT2 = 1'b0; contaT2 = 1'b0;

        for (int i = 0; i < 10; i++) aplica(tab[i]);
        for (int i = 0; i < 12; i++) bt(1'b1, 4'b0010, MJ | ME, 1'b0, 4'b0010, 2'd3, 1'b0);
        solta(4'b0010, 1'b0);

        // Bounce: 2-cycle toggling never survives the filter; then a steady press.
        for (int i = 0; i < 12; i++)
            bt(1'b1, (((i / 2) % 2) == 0) ? 4'b0010 : 4'b0000, MJ, 1'b0, 4'b0010, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            bt(1'b1, 4'b0010, MJ | ME, (i == 6), 4'b0010, est_press(i, 1'b1), 1'b0);
        solta(4'b0010, 1'b0);

        // Multi-press is dropped, then a single press of button 3 is accepted.
        for (int i = 0; i < 10; i++)
            bt(1'b1, 4'b0110, MJ | MC | ME, 1'b0, 4'b0010, est_press(i, 1'b0), 1'b0);
        solta(4'b0010, 1'b0);
        for (int i = 0; i < 10; i++)
            bt(1'b1, 4'b1000, MJ | MC | ME, (i == 6), (i < 6) ? 4'b0010 : 4'b1000, est_press(i, 1'b1), 1'b0);
        solta(4'b1000, 1'b0);

        // Timer T: saturating timeout, clear priority, hold while contaT=0.
        tmr(1'b1, 1'b0, 1'b0, 1'b0, MT, 1'b0, 1'b0);
        for (int i = 1; i <= 25; i++) tmr(1'b0, 1'b1, 1'b0, 1'b0, MT, (i >= 19), 1'b0);
        tmr(1'b1, 1'b1, 1'b0, 1'b0, MT, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) tmr(1'b0, 1'b1, 1'b0, 1'b0, MT, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) tmr(1'b0, 1'b0, 1'b0, 1'b0, MT, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) tmr(1'b0, 1'b1, 1'b0, 1'b0, MT, (i >= 9), 1'b0);

        // Timer T2: period-8 pulses, clear mid-period, hold while contaT2=0.
        tmr(1'b0, 1'b0, 1'b1, 1'b0, MT | MM, 1'b1, 1'b0);
        for (int j = 1; j <= 27; j++) tmr(1'b0, 1'b0, 1'b0, 1'b1, MT | MM, 1'b1, ((j % 8) == 7));
        tmr(1'b0, 1'b0, 1'b1, 1'b1, MT | MM, 1'b1, 1'b0);
        for (int j = 1; j <= 7; j++) tmr(1'b0, 1'b0, 1'b0, 1'b1, MT | MM, 1'b1, (j == 7));
        tmr(1'b0, 1'b0, 1'b0, 1'b0, MT | MM, 1'b1, 1'b0);
        tmr(1'b0, 1'b0, 1'b0, 1'b1, MT | MM, 1'b1, 1'b0);
        tmr(1'b0, 1'b0, 1'b0, 1'b0, MT | MM, 1'b1, 1'b0);

        // Reset while filtering a held button: clean restart, one pulse after full debounce.
        for (int i = 0; i < 4; i++)
            bt(1'b1, 4'b0100, MJ | MC | ME | MT, 1'b0, 4'b1000, est_press(i, 1'b1), 1'b1);
        aplica(mk(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, MJ | MC | ME | MT | MM, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++)
            bt(1'b1, 4'b0100, MJ | MC | ME | MT, (i == 6), (i < 6) ? 4'b0000 : 4'b0100, est_press(i, 1'b1), 1'b0);
        solta(4'b0100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
